// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width for the ALU and its arbiter.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    PINS = 2'b11
  } alu_op_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU datapath: add, logical shifts and parity-bit insert, plus an A==C compare.
module ALU
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPS = 2
) (
  input  logic [OPS-1:0] op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [W-1:0]   c_i,
  output logic [W-1:0]   result_o,
  output logic           isEqual
);

  typedef logic [W-1:0] word_t;
  localparam word_t W_L = word_t'(W);

  always_comb begin
    result_o = a_i;
    case (op_i)
      ADD:  result_o = a_i + b_i;
      SHR:  result_o = (b_i >= W_L) ? '0 : (a_i >> b_i);
      SHL:  result_o = (b_i >= W_L) ? '0 : (a_i << b_i);
      PINS: begin
        // An out-of-range bit position matches no index, leaving A unchanged.
        for (int i = 0; i < W; i++) begin
          if (b_i == word_t'(i)) result_o[i] = ^a_i;
        end
      end
      default: result_o = a_i;
    endcase
  end

  assign isEqual = (a_i == c_i);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a single registered
// result stage that issues a new operation in the same cycle the old one is consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W    = ALU_W,
  parameter int OPS  = 2,
  parameter int NREQ = 2,
  parameter int CNTW = 16,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPS-1:0] req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_out,
  output logic              rsp_eq,
  output logic [CNTW-1:0]   done_count
);

  // Returns {found, index}; search begins one past the last granted requester.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  last);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!found && v[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  rsp_state_t     state_q, state_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   out_q;
  logic           eq_q;
  logic [CNTW-1:0] done_q, done_d;

  logic [IDW:0]   pick;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic           can_issue;
  logic           issue;
  logic           consume;

  logic [OPS-1:0] sel_op;
  logic [W-1:0]   sel_a, sel_b, sel_c;
  logic [W-1:0]   alu_out;
  logic           alu_eq;

  assign pick      = rr_pick(req_valid, last_grant_q);
  assign gnt_vld   = pick[IDW];
  assign gnt_idx   = pick[IDW-1:0];
  assign rsp_valid = (state_q == RSP_FULL);
  assign can_issue = !rsp_valid || rsp_ready;
  assign issue     = gnt_vld && can_issue && !reset;
  assign consume   = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op = req_op[i*OPS +: OPS];
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_c  = req_c[i*W +: W];
      end
    end
  end

  ALU #(
    .W   (W),
    .OPS (OPS)
  ) u_alu (
    .op_i     (sel_op),
    .a_i      (sel_a),
    .b_i      (sel_b),
    .c_i      (sel_c),
    .result_o (alu_out),
    .isEqual  (alu_eq)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: if (issue) state_d = RSP_FULL;
      RSP_FULL: begin
        if (issue)          state_d = RSP_FULL;
        else if (rsp_ready) state_d = RSP_EMPTY;
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  always_comb begin
    done_d = done_q;
    if (consume) done_d = done_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RSP_EMPTY;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Result register and round-robin pointer only move on an issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      out_q        <= '0;
      eq_q         <= 1'b0;
    end else if (issue) begin
      last_grant_q <= gnt_idx;
      id_q         <= gnt_idx;
      out_q        <= alu_out;
      eq_q         <= alu_eq;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_out    = out_q;
  assign rsp_eq     = eq_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and hand-computed expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int OPS  = 2;
  localparam int NREQ = 2;
  localparam int CNTW = 16;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*OPS-1:0] req_op;
  logic [NREQ*W-1:0] req_a, req_b, req_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [W-1:0]      rsp_out;
  logic              rsp_eq;
  logic [CNTW-1:0]   done_count;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.W(W), .OPS(OPS), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_eq     (rsp_eq),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    req_valid[i]      = v;
    req_op[i*OPS +: OPS] = op;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_c[i*W +: W]   = c;
  endtask

  // Single req0 operation back-to-back with rsp_ready high.
  task automatic issue0(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] exp_out, input logic exp_eq);
    set_req(0, 1'b1, op, a, b, c);
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'h1);
    tick();
    chk({tag, "_out"}, 32'(rsp_out), 32'(exp_out));
    chk({tag, "_eq"}, 32'(rsp_eq), 32'(exp_eq));
    req_valid[0] = 1'b0;
  endtask

  logic [1:0] exp_rdy [4];
  logic [0:0] exp_id  [4];
  logic [7:0] exp_out [4];

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b0;
    tick();
    set_req(0, 1'b1, ADD, 8'hF0, 8'h20, 8'h10);
    rsp_ready = 1'b1;
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_out", 32'(rsp_out), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_eq", 32'(rsp_eq), 32'h0);
    chk("rst_done", 32'(done_count), 32'h0);

    // First transaction: ADD F0+20 = 10 with carry dropped
    reset = 1'b0;
    #1;
    chk("t1_rdy", 32'(req_ready), 32'h1);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_out", 32'(rsp_out), 32'h10);
    chk("t1_eq", 32'(rsp_eq), 32'h0);
    chk("t1_id", 32'(rsp_id), 32'h0);
    chk("t1_done0", 32'(done_count), 32'h0);
    req_valid = '0;
    tick();
    chk("t1_empty", 32'(rsp_valid), 32'h0);
    chk("t1_done1", 32'(done_count), 32'h1);

    // Both valid; last grant was 0 so rotation starts at 1
    set_req(0, 1'b1, SHL, 8'h01, 8'd3, 8'h00);
    set_req(1, 1'b1, SHR, 8'h80, 8'd7, 8'h00);
    exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_id  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_out = '{8'h01, 8'h08, 8'h01, 8'h08};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_rdy", i), 32'(req_ready), 32'(exp_rdy[i]));
      tick();
      chk($sformatf("rr%0d_id", i), 32'(rsp_id), 32'(exp_id[i]));
      chk($sformatf("rr%0d_out", i), 32'(rsp_out), 32'(exp_out[i]));
    end
    chk("rr_done_mid", 32'(done_count), 32'h4);
    req_valid = '0;
    tick();
    chk("rr_done", 32'(done_count), 32'h5);
    chk("rr_empty", 32'(rsp_valid), 32'h0);

    // Stall: hold a req1 result while req1 presents a new operation
    rsp_ready = 1'b0;
    set_req(1, 1'b1, ADD, 8'h05, 8'h06, 8'h0B);
    #1;
    chk("st_rdy0", 32'(req_ready), 32'h2);
    tick();
    chk("st_out0", 32'(rsp_out), 32'h0B);
    set_req(1, 1'b1, SHL, 8'h03, 8'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st%0d_rdy", i), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("st%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("st%0d_out", i), 32'(rsp_out), 32'h0B);
      chk($sformatf("st%0d_id", i), 32'(rsp_id), 32'h1);
    end
    chk("st_done_hold", 32'(done_count), 32'h5);
    rsp_ready = 1'b1;
    #1;
    chk("st_rel_rdy", 32'(req_ready), 32'h2);
    tick();
    chk("st_rel_out", 32'(rsp_out), 32'h0C);
    chk("st_rel_valid", 32'(rsp_valid), 32'h1);
    chk("st_rel_done", 32'(done_count), 32'h6);
    req_valid = '0;
    tick();
    chk("st_end_done", 32'(done_count), 32'h7);

    // Opcode boundaries
    issue0("pins4", PINS, 8'h07, 8'd4, 8'h00, 8'h17, 1'b0);
    issue0("pins9", PINS, 8'h03, 8'd9, 8'h00, 8'h03, 1'b0);
    issue0("pins8", PINS, 8'h02, 8'd8, 8'h00, 8'h02, 1'b0);
    issue0("pins0", PINS, 8'hFF, 8'd0, 8'h00, 8'hFE, 1'b0);
    issue0("shl8", SHL, 8'hFF, 8'd8, 8'h00, 8'h00, 1'b0);
    issue0("shr8", SHR, 8'hFF, 8'd8, 8'h00, 8'h00, 1'b0);
    issue0("addeq", ADD, 8'h5A, 8'h01, 8'h5A, 8'h5B, 1'b1);
    tick();
    chk("ops_done", 32'(done_count), 32'd14);

    // Reset while a result is held and req0 is still requesting
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ADD, 8'h11, 8'h22, 8'h00);
    tick();
    chk("mr_out_pre", 32'(rsp_out), 32'h33);
    rsp_ready = 1'b1;
    reset     = 1'b1;
    #1;
    chk("mr_rdy", 32'(req_ready), 32'h0);
    tick();
    chk("mr_valid", 32'(rsp_valid), 32'h0);
    chk("mr_out", 32'(rsp_out), 32'h0);
    chk("mr_id", 32'(rsp_id), 32'h0);
    chk("mr_eq", 32'(rsp_eq), 32'h0);
    chk("mr_done", 32'(done_count), 32'h0);
    reset = 1'b0;
    set_req(0, 1'b1, ADD, 8'h01, 8'h01, 8'h00);
    set_req(1, 1'b1, ADD, 8'h02, 8'h02, 8'h00);
    #1;
    chk("pr_rdy0", 32'(req_ready), 32'h1);
    tick();
    chk("pr_id0", 32'(rsp_id), 32'h0);
    chk("pr_out0", 32'(rsp_out), 32'h02);
    #1;
    chk("pr_rdy1", 32'(req_ready), 32'h2);
    tick();
    chk("pr_id1", 32'(rsp_id), 32'h1);
    chk("pr_out1", 32'(rsp_out), 32'h04);
    req_valid = '0;
    tick();
    chk("pr_done", 32'(done_count), 32'h2);

    // Counter wrap: 65533 more consumes reach FFFF, one more wraps to 0
    set_req(0, 1'b1, ADD, 8'h00, 8'h00, 8'h00);
    repeat (65533) @(posedge clk);
    #1;
    req_valid = '0;
    tick();
    chk("wrap_max", 32'(done_count), 32'hFFFF);
    req_valid[0] = 1'b1;
    tick();
    req_valid = '0;
    tick();
    chk("wrap_zero", 32'(done_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
